// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter family.
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Binary index of the set bit in a one-hot vector (up to 32 channels); 0 when empty.
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  // Beats per tenure: a zero weight, or the unweighted build, still gets one beat.
  function automatic logic [15:0] eff_weight(input logic [15:0] w, input logic weighted);
    return (weighted && (w != 16'd0)) ? w : 16'd1;
  endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Rotating-priority picker: first request at or after ptr, optionally ignoring one channel.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [IDX_W-1:0] mask_idx,
  input  logic             mask_en,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  logic [N-1:0]   cand;
  logic [N-1:0]   rot;
  logic [2*N-1:0] dbl;
  logic [IDX_W:0] sum;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign cand[gi]   = req[gi] & ~(mask_en & (mask_idx == IDX_W'(gi)));
      assign onehot[gi] = found & (idx == IDX_W'(gi));
    end
  endgenerate

  // rot[j] is channel (ptr + j) mod N, so the lowest set bit is the winner.
  assign dbl = {cand, cand} >> ptr;
  assign rot = dbl[N-1:0];

  always_comb begin
    found = 1'b0;
    sum   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDX_W+1)'(j);
      end
    end
    if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: owner keeps the grant for weight[k] accepted beats,
// optionally extended by lock; downstream backpressure never rotates the grant.
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int WEIGHT_W = 4,
  parameter int WEIGHTED = 1,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] weight,
  input  logic                  lock,
  input  logic                  grant_ready,
  output logic [N-1:0]          grant,
  output logic                  grant_valid,
  output logic [IDX_W-1:0]      grant_idx
);

  arb_state_e          state_reg, state_next;
  logic [IDX_W-1:0]    ptr_reg, ptr_next;
  logic [WEIGHT_W-1:0] credit_reg, credit_next;
  logic [N-1:0]        grant_reg, grant_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;

  logic [WEIGHT_W-1:0] w_arr [N];
  logic [IDX_W-1:0]    ptr_plus;
  logic                beat;
  logic                release_now;
  logic [IDX_W-1:0]    pick_ptr;
  logic                pick_mask_en;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [N-1:0]        pick_onehot;
  logic [WEIGHT_W-1:0] pick_credit;
  logic [WEIGHT_W-1:0] owner_credit;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_weight
      assign w_arr[gi] = weight[gi*WEIGHT_W +: WEIGHT_W];
    end
  endgenerate

  assign grant       = grant_reg;
  assign grant_valid = |grant_reg;
  assign grant_idx   = idx_reg;

  assign beat        = grant_valid & grant_ready;
  assign ptr_plus    = (idx_reg == IDX_W'(N - 1)) ? '0 : idx_reg + 1'b1;
  assign release_now = (state_reg == GRANT) &&
                       (!req[idx_reg] || (beat && (credit_reg == WEIGHT_W'(1)) && !lock));

  // On release the scan starts after the old owner and skips it; idle scans start at ptr.
  assign pick_ptr     = release_now ? ptr_plus : ptr_reg;
  assign pick_mask_en = release_now;

  assign pick_credit  = WEIGHT_W'(eff_weight(16'(w_arr[pick_idx]), WEIGHTED != 0));
  assign owner_credit = WEIGHT_W'(eff_weight(16'(w_arr[idx_reg]), WEIGHTED != 0));

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (req),
    .ptr      (pick_ptr),
    .mask_idx (idx_reg),
    .mask_en  (pick_mask_en),
    .found    (pick_found),
    .idx      (pick_idx),
    .onehot   (pick_onehot)
  );

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    credit_next = credit_reg;
    grant_next  = grant_reg;
    idx_next    = idx_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next  = GRANT;
          grant_next  = pick_onehot;
          idx_next    = pick_idx;
          credit_next = pick_credit;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_next = ptr_plus;
          if (pick_found) begin
            grant_next  = pick_onehot;
            idx_next    = pick_idx;
            credit_next = pick_credit;
          end else if (req[idx_reg]) begin
            credit_next = owner_credit;
          end else begin
            state_next  = IDLE;
            grant_next  = '0;
            idx_next    = '0;
            credit_next = '0;
          end
        end else if (beat && !lock) begin
          credit_next = credit_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      credit_reg <= '0;
      grant_reg  <= '0;
      idx_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      credit_reg <= credit_next;
      grant_reg  <= grant_next;
      idx_reg    <= idx_next;
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: per-cycle vector table for the weighted build plus
// a hand sequence on an unweighted 3-channel build.
module tb_wrr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Weighted 4-channel instance.
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] weight = '0;
  logic        lock = 1'b0;
  logic        ready = 1'b1;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_idx;

  // Unweighted 3-channel instance.
  logic        rst_b = 1'b1;
  logic [2:0]  req_b = '0;
  logic [11:0] weight_b = '0;
  logic        lock_b = 1'b0;
  logic        ready_b = 1'b1;
  logic [2:0]  grant_b;
  logic        grant_valid_b;
  logic [1:0]  grant_idx_b;

  int checks = 0;
  int errors = 0;

  wrr_arbiter #(.N(4), .WEIGHT_W(4), .WEIGHTED(1)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .weight      (weight),
    .lock        (lock),
    .grant_ready (ready),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  wrr_arbiter #(.N(3), .WEIGHT_W(4), .WEIGHTED(0)) dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .req         (req_b),
    .weight      (weight_b),
    .lock        (lock_b),
    .grant_ready (ready_b),
    .grant       (grant_b),
    .grant_valid (grant_valid_b),
    .grant_idx   (grant_idx_b)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] w;
    logic        lock;
    logic        ready;
    logic [3:0]  exp;
    int          tag;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] q, input logic [15:0] w,
                     input logic l, input logic rd, input logic [3:0] e, input int t);
    vec_t v;
    v.rst = r; v.req = q; v.w = w; v.lock = l; v.ready = rd; v.exp = e; v.tag = t;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] oh_idx(input logic [3:0] g);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Structural invariants on both instances every cycle.
  always @(negedge clk) begin
    check("a_onehot0", 32'($onehot0(grant)), 32'd1);
    check("a_valid_or", 32'(grant_valid), 32'(|grant));
    check("a_idx_match", 32'(grant_idx), oh_idx(grant));
    check("b_onehot0", 32'($onehot0(grant_b)), 32'd1);
    check("b_valid_or", 32'(grant_valid_b), 32'(|grant_b));
    check("b_idx_match", 32'(grant_idx_b), oh_idx({1'b0, grant_b}));
  end

  initial begin
    logic [2:0] prev;
    logic [2:0] exp_b;

    // Sole requester ch0 weight 3: held, re-granted fresh, then 3 beats before moving to ch1.
    add(1, 4'b0000, 16'h0003, 0, 1, 4'b0000, 1);
    add(0, 4'b0000, 16'h0003, 0, 1, 4'b0000, 1);
    repeat (4) add(0, 4'b0001, 16'h0003, 0, 1, 4'b0001, 1);
    repeat (2) add(0, 4'b0011, 16'h0003, 0, 1, 4'b0001, 1);
    add(0, 4'b0011, 16'h0003, 0, 1, 4'b0010, 1);
    // All request, weights 1,2,3,4: back-to-back tenures.
    add(1, 4'b1111, 16'h4321, 0, 1, 4'b0000, 3);
    add(0, 4'b1111, 16'h4321, 0, 1, 4'b0001, 3);
    repeat (2) add(0, 4'b1111, 16'h4321, 0, 1, 4'b0010, 3);
    repeat (3) add(0, 4'b1111, 16'h4321, 0, 1, 4'b0100, 3);
    repeat (4) add(0, 4'b1111, 16'h4321, 0, 1, 4'b1000, 3);
    add(0, 4'b1111, 16'h4321, 0, 1, 4'b0001, 3);
    add(0, 4'b1111, 16'h4321, 0, 1, 4'b0010, 3);
    // Backpressure mid-tenure freezes credit: 4 accepted beats on ch1.
    add(1, 4'b0110, 16'h0140, 0, 1, 4'b0000, 4);
    repeat (2) add(0, 4'b0110, 16'h0140, 0, 1, 4'b0010, 4);
    repeat (5) add(0, 4'b0110, 16'h0140, 0, 0, 4'b0010, 4);
    repeat (2) add(0, 4'b0110, 16'h0140, 0, 1, 4'b0010, 4);
    add(0, 4'b0110, 16'h0140, 0, 1, 4'b0100, 4);
    add(0, 4'b0110, 16'h0140, 0, 1, 4'b0010, 4);
    // Lock holds ch2, unlock releases to ch3, early req drop moves to ch0.
    add(1, 4'b0100, 16'h4111, 0, 1, 4'b0000, 5);
    add(0, 4'b0100, 16'h4111, 0, 1, 4'b0100, 5);
    repeat (6) add(0, 4'b1111, 16'h4111, 1, 1, 4'b0100, 5);
    add(0, 4'b1111, 16'h4111, 0, 1, 4'b1000, 5);
    add(0, 4'b0111, 16'h4111, 0, 1, 4'b0001, 5);
    // Reset during ch3 tenure (ptr was 2) -> ptr back to 0, ch1 wins; ch1 weight 0 acts as 1.
    add(1, 4'b1010, 16'h4000, 0, 1, 4'b0000, 6);
    add(0, 4'b1010, 16'h4000, 0, 1, 4'b0010, 6);
    repeat (2) add(0, 4'b1010, 16'h4000, 0, 1, 4'b1000, 6);
    add(1, 4'b1010, 16'h4000, 0, 1, 4'b0000, 6);
    add(0, 4'b1010, 16'h4000, 0, 1, 4'b0010, 6);

    foreach (vecs[i]) begin
      rst    = vecs[i].rst;
      req    = vecs[i].req;
      weight = vecs[i].w;
      lock   = vecs[i].lock;
      ready  = vecs[i].ready;
      @(posedge clk);
      #1;
      check($sformatf("t%0d_v%0d_grant", vecs[i].tag, i), 32'(grant), 32'(vecs[i].exp));
      check($sformatf("t%0d_v%0d_valid", vecs[i].tag, i), 32'(grant_valid), 32'(|vecs[i].exp));
      check($sformatf("t%0d_v%0d_idx", vecs[i].tag, i), 32'(grant_idx), oh_idx(vecs[i].exp));
      $display("vec %0d test %0d rst=%b req=%b lock=%b ready=%b grant=%b idx=%0d",
               i, vecs[i].tag, vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].ready,
               grant, grant_idx);
    end

    // Unweighted 3-channel build: plain round robin, one beat each, weights ignored.
    rst_b    = 1'b1;
    req_b    = 3'b111;
    weight_b = 12'h333;
    @(posedge clk);
    #1;
    check("t2_reset_grant", 32'(grant_b), 32'd0);
    rst_b = 1'b0;
    prev  = '0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      exp_b = 3'b001 << (i % 3);
      check($sformatf("t2_c%0d_grant", i), 32'(grant_b), 32'(exp_b));
      check($sformatf("t2_c%0d_norepeat", i), 32'(grant_b != prev), 32'd1);
      $display("t2 cycle %0d grant=%b idx=%0d", i, grant_b, grant_idx_b);
      prev = grant_b;
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
